// File: rtl/rhd_spi_responder.sv
// RHD2000 SPI slave model: synchronizes CS/SCLK/MOSI, decodes 16-bit commands,
// holds the register file and answers on MISO with the two-frame pipeline latency.
module rhd_spi_responder #(
    parameter int NUM_AMPS = 32,
    parameter int CHIP_ID  = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int         AMP_LIM_I  = (NUM_AMPS > 64) ? 64 : NUM_AMPS;
    localparam logic [6:0] AMP_LIMIT  = 7'(AMP_LIM_I);
    localparam logic [7:0] NUM_AMPS_B = 8'(NUM_AMPS);
    localparam logic [7:0] CHIP_ID_B  = 8'(CHIP_ID);

    logic [2:0]  cs_sync;
    logic [2:0]  sclk_sync;
    logic [1:0]  mosi_sync;
    logic        cs_fall;
    logic        cs_rise;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_s;

    logic [1:0]  state;
    logic [15:0] rx;
    logic [4:0]  bitcnt;
    logic [15:0] tx;
    logic [15:0] out_next;
    logic [15:0] pipe;
    logic [9:0]  frame_cnt;
    logic [7:0]  regs [0:17];

    logic [1:0]  op;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic [7:0]  reg_rd;
    logic [15:0] result;
    logic        do_write;
    logic        cnt_inc;
    logic        frame_ok;

    // CS flops reset low so a frame already in progress at reset release
    // produces no falling edge and is ignored until CS rises and falls again.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[1:0], CS};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    assign cs_fall   =  cs_sync[2]   & ~cs_sync[1];
    assign cs_rise   = ~cs_sync[2]   &  cs_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
    assign mosi_s    =  mosi_sync[1];

    assign op       = rx[15:14];
    assign addr     = rx[13:8];
    assign data     = rx[7:0];
    assign frame_ok = (bitcnt == 5'd16);

    always_comb begin
        reg_rd = 8'h00;
        if (addr <= 6'd17) begin
            reg_rd = regs[addr[4:0]];
        end else begin
            case (addr)
                6'd40:   reg_rd = 8'h49;
                6'd41:   reg_rd = 8'h4E;
                6'd42:   reg_rd = 8'h54;
                6'd43:   reg_rd = 8'h41;
                6'd44:   reg_rd = 8'h4E;
                6'd62:   reg_rd = NUM_AMPS_B;
                6'd63:   reg_rd = CHIP_ID_B;
                default: reg_rd = 8'h00;
            endcase
        end
    end

    // The result uses frame_cnt before the channel-0 increment takes effect.
    always_comb begin
        result   = 16'h0000;
        do_write = 1'b0;
        cnt_inc  = 1'b0;
        case (op)
            2'b00: begin
                if ({1'b0, addr} < AMP_LIMIT) begin
                    result = {addr, frame_cnt};
                end
                cnt_inc = (addr == 6'd0);
            end
            2'b01: begin
                result = 16'h0000;
            end
            2'b10: begin
                result   = {8'hFF, data};
                do_write = (addr <= 6'd17);
            end
            default: begin
                result = {8'h00, reg_rd};
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            rx        <= '0;
            bitcnt    <= '0;
            tx        <= '0;
            out_next  <= '0;
            pipe      <= '0;
            frame_cnt <= '0;
            cmd_valid <= 1'b0;
            cmd_word  <= '0;
            frame_err <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state  <= ST_SHIFT;
                        tx     <= out_next;
                        rx     <= '0;
                        bitcnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // A CS rise takes priority over any SCLK edge in the same cycle.
                    if (cs_rise) begin
                        state <= ST_DONE;
                    end else begin
                        if (sclk_rise) begin
                            rx <= {rx[14:0], mosi_s};
                            if (bitcnt != 5'd31) begin
                                bitcnt <= bitcnt + 5'd1;
                            end
                        end
                        if (sclk_fall) begin
                            tx <= {tx[14:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (frame_ok) begin
                        out_next  <= pipe;
                        pipe      <= result;
                        cmd_valid <= 1'b1;
                        cmd_word  <= rx;
                        if (cnt_inc) begin
                            frame_cnt <= frame_cnt + 10'd1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < 18; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (state == ST_DONE && frame_ok && do_write) begin
            regs[addr[4:0]] <= data;
        end
    end

    assign MISO = (state == ST_SHIFT) & tx[15];

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Scoreboard bench for rhd_spi_responder: a driver bit-bangs SPI frames and queues
// expected responses, a monitor pops and compares on every cmd_valid pulse.
module tb_rhd_spi_responder;

    logic        aclk = 1'b0;
    logic        areset;
    logic        CS;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_cmd_q  [$];
    logic [15:0] exp_miso_q [$];
    logic [15:0] obs_miso_q [$];

    logic [15:0] exp_out_next;
    logic [15:0] exp_pipe;
    logic [9:0]  exp_cnt;
    int          sclk_half;
    time         cs_rise_t;

    always #5 aclk = ~aclk;

    rhd_spi_responder #(
        .NUM_AMPS(32),
        .CHIP_ID (1)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .CS       (CS),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .cmd_valid(cmd_valid),
        .cmd_word (cmd_word),
        .frame_err(frame_err)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Reference pipeline: a frame shifts out what out_next held when it started.
    task automatic expectFrame(input logic [15:0] cmd, input logic [15:0] res);
        exp_cmd_q.push_back(cmd);
        exp_miso_q.push_back(exp_out_next);
        exp_out_next = exp_pipe;
        exp_pipe     = res;
    endtask

    task automatic resetModel();
        exp_out_next = 16'h0000;
        exp_pipe     = 16'h0000;
        exp_cnt      = 10'd0;
    endtask

    // MISO is sampled 35 ns after the preceding falling edge (or CS fall),
    // which clears the 3-cycle response latency at either SCLK rate used here.
    task automatic applyStimulus(input logic [15:0] cmd, input int nbits, input int reset_at);
        logic [15:0] cap;
        cap = '0;
        CS  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                @(negedge aclk);
                areset = 1'b1;
                @(negedge aclk);
                areset = 1'b0;
                checkOutput("midreset_miso",      {15'd0, MISO},      16'h0000);
                checkOutput("midreset_cmd_valid", {15'd0, cmd_valid}, 16'h0000);
                checkOutput("midreset_cmd_word",  cmd_word,           16'h0000);
                checkOutput("midreset_frame_err", {15'd0, frame_err}, 16'h0000);
                resetModel();
                #2;
            end
            MOSI = cmd[15-i];
            #(sclk_half);
            SCLK = 1'b1;
            #(35 - sclk_half);
            cap = {cap[14:0], MISO};
            #(2*sclk_half - 35);
            SCLK = 1'b0;
        end
        #20;
        if (nbits == 16 && reset_at < 0) begin
            obs_miso_q.push_back(cap);
        end
        CS        = 1'b1;
        cs_rise_t = $time;
        MOSI      = 1'b0;
        #60;
    endtask

    task automatic sendFrame(input logic [15:0] cmd, input logic [15:0] res);
        expectFrame(cmd, res);
        applyStimulus(cmd, 16, -1);
    endtask

    task automatic convFrame(input logic [5:0] ch, input logic hbit);
        logic [15:0] res;
        res = (ch < 6'd32) ? {ch, exp_cnt} : 16'h0000;
        if (ch == 6'd0) begin
            exp_cnt = exp_cnt + 10'd1;
        end
        sendFrame({2'b00, ch, 7'd0, hbit}, res);
    endtask

    // cmd_valid lands on the 4th aclk edge after the CS rise pin edge,
    // seen here on the following falling edge, 38 ns after the pin change.
    always @(negedge aclk) begin
        if (!areset && cmd_valid === 1'b1) begin
            if (exp_cmd_q.size() == 0 || obs_miso_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_cmd_valid: pulse with cmd_word 0x%04h, expected no pulse", cmd_word);
            end else begin
                checkOutput("cmd_word", cmd_word, exp_cmd_q.pop_front());
                checkOutput("miso_word", obs_miso_q.pop_front(), exp_miso_q.pop_front());
                checks++;
                if ($time - cs_rise_t != 38) begin
                    errors++;
                    $display("[TB] FAIL cmd_valid_latency: got %0t after CS rise, expected 38", $time - cs_rise_t);
                end
            end
        end
    end

    initial begin
        areset    = 1'b1;
        CS        = 1'b1;
        SCLK      = 1'b0;
        MOSI      = 1'b0;
        sclk_half = 30;
        cs_rise_t = 0;
        resetModel();
        repeat (2) @(negedge aclk);
        checkOutput("reset_miso",      {15'd0, MISO},      16'h0000);
        checkOutput("reset_cmd_valid", {15'd0, cmd_valid}, 16'h0000);
        checkOutput("reset_cmd_word",  cmd_word,           16'h0000);
        checkOutput("reset_frame_err", {15'd0, frame_err}, 16'h0000);
        areset = 1'b0;
        #2;
        #100;

        $display("[TB] ROM read INTAN");
        sendFrame(16'hE800, 16'h0049);
        sendFrame(16'hE900, 16'h004E);
        sendFrame(16'hEA00, 16'h0054);
        sendFrame(16'hEB00, 16'h0041);
        sendFrame(16'hEC00, 16'h004E);
        sendFrame(16'hC000, 16'h0000);
        sendFrame(16'hC000, 16'h0000);

        $display("[TB] write then read");
        sendFrame(16'h85A3, 16'hFFA3);
        sendFrame(16'hC500, 16'h00A3);
        sendFrame(16'hC000, 16'h0000);
        sendFrame(16'hC000, 16'h0000);
        sendFrame(16'h915A, 16'hFF5A);
        sendFrame(16'hD100, 16'h005A);
        sendFrame(16'h9477, 16'hFF77);
        sendFrame(16'hD400, 16'h0000);

        $display("[TB] boundary commands");
        sendFrame(16'h2800, 16'h0000);
        sendFrame(16'hFF00, 16'h0001);
        sendFrame(16'hFE00, 16'h0020);
        sendFrame(16'h5500, 16'h0000);
        sendFrame(16'h6A00, 16'h0000);
        sendFrame(16'h1F00, 16'h7C00);
        sendFrame(16'h2000, 16'h0000);

        $display("[TB] convert sweep");
        sclk_half = 20;
        for (int i = 0; i < 1030; i++) begin
            convFrame((i % 256 == 255) ? 6'd1 : 6'd0, 1'(i & 1));
        end
        sclk_half = 30;
        sendFrame(16'hC000, 16'h0000);
        sendFrame(16'hC000, 16'h0000);

        $display("[TB] short frame");
        checkOutput("frame_err_before_short", {15'd0, frame_err}, 16'h0000);
        applyStimulus(16'hC000, 15, -1);
        checkOutput("frame_err_after_short", {15'd0, frame_err}, 16'h0001);
        sendFrame(16'hE900, 16'h004E);
        sendFrame(16'hC000, 16'h0000);
        sendFrame(16'hC000, 16'h0000);

        $display("[TB] reset mid-frame");
        applyStimulus(16'hC500, 16, 8);
        sendFrame(16'hC500, 16'h0000);
        sendFrame(16'h853C, 16'hFF3C);
        sendFrame(16'hC500, 16'h003C);
        sendFrame(16'hFF00, 16'h0001);
        convFrame(6'd0, 1'b0);
        sendFrame(16'hC000, 16'h0000);
        sendFrame(16'hC000, 16'h0000);

        #200;
        checkOutput("frame_err_final", {15'd0, frame_err}, 16'h0000);
        checkOutput("pending_frames", 16'(exp_cmd_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
